// File: rtl/serializador_param_if.sv
// Handshake and serial-output bundle for serializador_param.
interface serializador_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_sof;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_bit, out_valid, out_sof, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_bit, out_valid, out_sof, busy
    );
endinterface

// File: rtl/serializador_param.sv
// Parametrised parallel-to-serial converter with a one-word holding buffer,
// gapless back-to-back streaming and per-word start-of-frame flag.
module serializador_param #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_VAL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serializador_param_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;

    logic             ready;
    logic             accept;
    logic             retire;
    logic             reload;
    logic             first_bit;
    logic [CW-1:0]    idx;
    logic             cur_bit;

    assign ready  = rst_n && !hold_full_q;
    assign accept = bus.in_valid && ready;
    // cnt wraps to 0 on the last-bit edge, so cnt==0 inside SHIFT marks the retire edge
    assign retire = (state_q == SHIFT) && (cnt_q == '0);
    assign reload = hold_full_q && ((state_q == IDLE) || retire);

    assign first_bit = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
    assign idx       = MSB_FIRST ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;
    assign cur_bit   = sh_q[idx];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hold_full_q) state_d = SHIFT;
            SHIFT:   if (retire && !hold_full_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for datapath and registered outputs
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        out_bit_d   = IDLE_VAL;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;

        if (accept) begin
            hold_d      = bus.in_data;
            hold_full_d = 1'b1;
        end

        if (reload) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
            out_bit_d   = first_bit;
            out_valid_d = 1'b1;
            out_sof_d   = 1'b1;
            cnt_d       = CW'(1);
        end else if (state_q == SHIFT) begin
            if (retire) begin
                cnt_d = '0;
            end else begin
                out_bit_d   = cur_bit;
                out_valid_d = 1'b1;
                cnt_d       = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + CW'(1);
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            out_bit_q   <= IDLE_VAL;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.busy      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serializador_param.sv
// Directed bench for serializador_param: 8-bit MSB-first and 4-bit LSB-first instances.
module tb_serializador_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serializador_param_if #(.WIDTH(8)) if8 ();
    serializador_param_if #(.WIDTH(4)) if4 ();

    serializador_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8.slave)
    );
    serializador_param #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Drives up to three words with in_valid held high and records the output stream.
    task automatic drive_capture(input bit sel4, input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [7:0] w2, input int nw, input int ncyc,
                                 output logic [63:0] bits, output logic [63:0] sofs,
                                 output int nv, output int first_v, output int last_v,
                                 output int first_acc, output int nacc, output int stalls,
                                 output int busy_err);
        logic [7:0] w [3];
        int  widx;
        bit  acc_pending;
        logic ov, ob, os, bz, rdy, vld;
        w[0] = w0; w[1] = w1; w[2] = w2;
        bits = '0; sofs = '0; nv = 0; first_v = -1; last_v = -1;
        first_acc = -1; nacc = 0; stalls = 0; busy_err = 0;
        widx = 0; acc_pending = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            ov = sel4 ? if4.out_valid : if8.out_valid;
            ob = sel4 ? if4.out_bit   : if8.out_bit;
            os = sel4 ? if4.out_sof   : if8.out_sof;
            bz = sel4 ? if4.busy      : if8.busy;
            if (ov) begin
                if (nv < 64) begin
                    bits[nv] = ob;
                    sofs[nv] = os;
                end
                if (first_v < 0) first_v = i;
                last_v = i;
                nv++;
                if (!bz) busy_err++;
            end
            if (acc_pending) begin
                nacc++;
                widx++;
            end
            vld = (widx < nw);
            if (sel4) begin
                if4.in_valid = vld;
                if4.in_data  = vld ? w[widx][3:0] : 4'h0;
            end else begin
                if8.in_valid = vld;
                if8.in_data  = vld ? w[widx] : 8'h00;
            end
            rdy = sel4 ? if4.in_ready : if8.in_ready;
            acc_pending = vld && rdy;
            if (vld && !rdy) stalls++;
            if (acc_pending && first_acc < 0) first_acc = i;
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        if4.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if8.in_valid = 1'b0; if8.in_data = '0;
        if4.in_valid = 1'b0; if4.in_data = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (if8.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", if8.in_ready); end
        n_checks++;
        if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", if8.out_valid); end
        n_checks++;
        if (if4.out_bit !== 1'b1) begin n_fail++; $display("FAIL reset_idle_val4 got=%b exp=1", if4.out_bit); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if8.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", if8.in_ready); end
        n_checks++;
        if (if8.busy !== 1'b0) begin n_fail++; $display("FAIL release_busy got=%b exp=0", if8.busy); end

        // Reset asserted in the middle of a word
        if8.in_data = 8'h5A; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        for (int i = 0; i < 10 && !if8.out_valid; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (if8.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrun_streaming got=%b exp=1", if8.out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if8.out_valid, if8.out_sof, if8.out_bit, if8.in_ready, if8.busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrun_reset {valid,sof,bit,ready,busy} got=%b exp=00000",
                     {if8.out_valid, if8.out_sof, if8.out_bit, if8.in_ready, if8.busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({if8.in_ready, if8.busy, if8.out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL midrun_release {ready,busy,valid} got=%b exp=100",
                     {if8.in_ready, if8.busy, if8.out_valid});
        end
    endtask

    task automatic test_single();
        logic [63:0] bits, sofs;
        int nv, fv, lv, fa, na, st, be;
        drive_capture(1'b0, 8'hA5, 8'h00, 8'h00, 1, 14, bits, sofs, nv, fv, lv, fa, na, st, be);
        n_checks++;
        if (nv !== 8) begin n_fail++; $display("FAIL single_count got=%0d exp=8", nv); end
        n_checks++;
        if (bits[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_bits got=%h exp=a5", bits[7:0]); end
        n_checks++;
        if (sofs[7:0] !== 8'h01) begin n_fail++; $display("FAIL single_sof got=%h exp=01", sofs[7:0]); end
        n_checks++;
        if (fv !== fa + 2) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", fv, fa + 2); end
        n_checks++;
        if (lv - fv + 1 !== 8) begin n_fail++; $display("FAIL single_contig got=%0d exp=8", lv - fv + 1); end
        n_checks++;
        if ({if8.out_valid, if8.busy, if8.out_bit, if8.in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_idle {valid,busy,bit,ready} got=%b exp=0001",
                     {if8.out_valid, if8.busy, if8.out_bit, if8.in_ready});
        end
        n_checks++;
        if (be !== 0) begin n_fail++; $display("FAIL single_busy got=%0d exp=0", be); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bits, sofs;
        int nv, fv, lv, fa, na, st, be;
        drive_capture(1'b0, 8'hA5, 8'h3C, 8'h00, 2, 24, bits, sofs, nv, fv, lv, fa, na, st, be);
        n_checks++;
        if (nv !== 16) begin n_fail++; $display("FAIL b2b_count got=%0d exp=16", nv); end
        n_checks++;
        if (lv - fv + 1 !== 16) begin n_fail++; $display("FAIL b2b_contig got=%0d exp=16", lv - fv + 1); end
        n_checks++;
        if (bits[15:0] !== 16'h3CA5) begin n_fail++; $display("FAIL b2b_bits got=%h exp=3ca5", bits[15:0]); end
        n_checks++;
        if (sofs[15:0] !== 16'h0101) begin n_fail++; $display("FAIL b2b_sof got=%h exp=0101", sofs[15:0]); end
    endtask

    task automatic test_lsb_first();
        logic [63:0] bits, sofs;
        int nv, fv, lv, fa, na, st, be;
        drive_capture(1'b1, 8'h01, 8'h08, 8'h00, 2, 16, bits, sofs, nv, fv, lv, fa, na, st, be);
        n_checks++;
        if (nv !== 8) begin n_fail++; $display("FAIL lsb_count got=%0d exp=8", nv); end
        n_checks++;
        if (bits[7:0] !== 8'h81) begin n_fail++; $display("FAIL lsb_bits got=%h exp=81", bits[7:0]); end
        n_checks++;
        if (sofs[7:0] !== 8'h11) begin n_fail++; $display("FAIL lsb_sof got=%h exp=11", sofs[7:0]); end
        n_checks++;
        if (lv - fv + 1 !== 8) begin n_fail++; $display("FAIL lsb_contig got=%0d exp=8", lv - fv + 1); end
        n_checks++;
        if (if4.out_bit !== 1'b1) begin n_fail++; $display("FAIL lsb_idle_val got=%b exp=1", if4.out_bit); end
    endtask

    task automatic test_backpressure();
        logic [63:0] bits, sofs;
        int nv, fv, lv, fa, na, st, be;
        drive_capture(1'b0, 8'h12, 8'h34, 8'h0F, 3, 32, bits, sofs, nv, fv, lv, fa, na, st, be);
        n_checks++;
        if (nv !== 24) begin n_fail++; $display("FAIL bp_count got=%0d exp=24", nv); end
        n_checks++;
        if (bits[23:0] !== 24'hF02C48) begin n_fail++; $display("FAIL bp_bits got=%h exp=f02c48", bits[23:0]); end
        n_checks++;
        if (sofs[23:0] !== 24'h010101) begin n_fail++; $display("FAIL bp_sof got=%h exp=010101", sofs[23:0]); end
        n_checks++;
        if (na !== 3) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=3", na); end
        n_checks++;
        if (st == 0) begin n_fail++; $display("FAIL bp_stall got=%0d exp=>0", st); end
        n_checks++;
        if (lv - fv + 1 !== 24) begin n_fail++; $display("FAIL bp_contig got=%0d exp=24", lv - fv + 1); end
        n_checks++;
        if (be !== 0) begin n_fail++; $display("FAIL bp_busy got=%0d exp=0", be); end
    endtask

    task automatic test_reset_mid_word();
        logic [63:0] bits, sofs;
        int nv, fv, lv, fa, na, st, be;
        int nb, bad;
        if8.in_data = 8'hFF; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_data = 8'h00;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if8.out_valid) nb++;
            if (nb == 3) break;
        end
        n_checks++;
        if ({nb == 3, if8.in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL midword_setup bits=%0d ready=%b exp bits=3 ready=0", nb, if8.in_ready);
        end
        rst_n = 1'b0;
        if8.in_valid = 1'b0;
        #1;
        n_checks++;
        if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL midword_reset_valid got=%b exp=0", if8.out_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if8.out_valid || if8.busy) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midword_no_trailing got=%0d exp=0", bad); end
        drive_capture(1'b0, 8'hC3, 8'h00, 8'h00, 1, 14, bits, sofs, nv, fv, lv, fa, na, st, be);
        n_checks++;
        if (nv !== 8 || bits[7:0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL midword_recover count=%0d bits=%h exp count=8 bits=c3", nv, bits[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_backpressure();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
